axi_burst_addr_gen: RTL

AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

---
 rtl/axi_burst_addr_gen_pkg.sv | 39 +++
 rtl/axi_next_addr.sv | 48 ++++
 rtl/axi_burst_addr_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared types for the AXI burst address generator: burst encodings, FSM states
// and the legal WRAP lengths.
package axi_burst_addr_gen_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [7:0] WRAP_LEN_2  = 8'd1;
    localparam logic [7:0] WRAP_LEN_4  = 8'd3;
    localparam logic [7:0] WRAP_LEN_8  = 8'd7;
    localparam logic [7:0] WRAP_LEN_16 = 8'd15;

    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == WRAP_LEN_2) || (len == WRAP_LEN_4) ||
               (len == WRAP_LEN_8) || (len == WRAP_LEN_16);
    endfunction

    // log2 of the beat count for a legal WRAP length
    function automatic logic [2:0] wrap_log2(input logic [7:0] len);
        logic [2:0] lg;
        case (len)
            WRAP_LEN_2: lg = 3'd1;
            WRAP_LEN_4: lg = 3'd2;
            WRAP_LEN_8: lg = 3'd3;
            default:    lg = 3'd4;
        endcase
        return lg;
    endfunction

endpackage

// File: rtl/axi_next_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// WRAP arithmetic exists only when AXI_BURST_WRAP_EN is defined.
module axi_next_addr
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  burst_t            burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] incr_next;

    assign step      = ADDR_W'(1) << size;
    assign aligned   = addr & ~(step - ADDR_W'(1));
    assign incr_next = aligned + step;

`ifdef AXI_BURST_WRAP_EN
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] lower;
    logic [ADDR_W-1:0] wrap_next;

    // len is guaranteed legal here; illegal WRAPs are demoted to INCR upstream
    assign total     = step << wrap_log2(len);
    assign lower     = addr & ~(total - ADDR_W'(1));
    assign wrap_next = (incr_next == (lower + total)) ? lower : incr_next;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = incr_next;
        case (burst)
            BURST_FIXED: next_addr = addr;
`ifdef AXI_BURST_WRAP_EN
            BURST_WRAP:  next_addr = wrap_next;
`endif
            default:     next_addr = incr_next;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: turns one AW/AR command into per-beat addresses.
// Optional WRAP support via AXI_BURST_WRAP_EN (undefined: WRAP runs as INCR with cmd_err).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high (after reset release)
// ST_BURST | presenting beats; leaves after the beat_last handshake
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ID_W-1:0]   beat_id,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [7:0]        beat_idx,
    output logic              beat_last,
    output logic              cmd_err,
    output logic              busy
);

    state_t            state, state_nxt;
    burst_t            burst_eff, burst_q;
    logic              err_cmd;
    logic              cmd_hs, beat_hs, last_hit;
    logic              ready_q, err_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        len_q, idx_q;
    logic [2:0]        size_q;

    always_comb begin
        burst_eff = BURST_INCR;
        err_cmd   = 1'b0;
        case (burst_t'(cmd_burst))
            BURST_FIXED: burst_eff = BURST_FIXED;
            BURST_INCR:  burst_eff = BURST_INCR;
            BURST_WRAP: begin
`ifdef AXI_BURST_WRAP_EN
                if (is_wrap_len(cmd_len)) begin
                    burst_eff = BURST_WRAP;
                end else begin
                    err_cmd = 1'b1;
                end
`else
                err_cmd = 1'b1;
`endif
            end
            default:     err_cmd = 1'b1;
        endcase
    end

    assign cmd_hs   = cmd_valid && ready_q;
    assign beat_hs  = (state == ST_BURST) && beat_ready;
    assign last_hit = (idx_q == len_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_hs) state_nxt = ST_BURST;
            ST_BURST: if (beat_hs && last_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    axi_next_addr #(
        .ADDR_W (ADDR_W)
    ) u_next_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    // cmd_ready is registered so it stays low through reset and rises on the first edge after
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_INCR;
        end else begin
            ready_q <= (state_nxt == ST_IDLE);
            err_q   <= cmd_hs && err_cmd;
            if (cmd_hs) begin
                id_q    <= cmd_id;
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                idx_q   <= '0;
                size_q  <= cmd_size;
                burst_q <= burst_eff;
            end else if (beat_hs && !last_hit) begin
                addr_q <= addr_nxt;
                idx_q  <= idx_q + 8'd1;
            end
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = (state == ST_BURST);
    assign beat_valid = (state == ST_BURST);
    assign beat_last  = (state == ST_BURST) && last_hit;
    assign beat_id    = id_q;
    assign beat_addr  = addr_q;
    assign beat_idx   = idx_q;
    assign cmd_err    = err_q;

endmodule
